// File: rtl/reg_bus_read_sequencer_if.sv
// Interface between the register-bus read sequencer and its environment.
// It carries the request stream, the shared tri-state bus, and the sampled-word stream.
interface reg_bus_read_sequencer_if #(
  parameter int unsigned NrOfBits = 8,
  parameter int unsigned NrOfRegs = 4,
  parameter int unsigned IdxBits  = 2,
  parameter int unsigned CntBits  = 3
);
  logic                Tick;
  logic                ReqValid;
  logic                ReqReady;
  logic [IdxBits-1:0]  ReqStart;
  logic [CntBits-1:0]  ReqCount;
  logic [NrOfRegs-1:0] cs;
  logic [NrOfBits-1:0] BusIn;
  logic                OutValid;
  logic                OutReady;
  logic [NrOfBits-1:0] OutData;
  logic [IdxBits-1:0]  OutIndex;
  logic                OutLast;
  logic                Busy;

  modport master (
    input  Tick, ReqValid, ReqStart, ReqCount, BusIn, OutReady,
    output ReqReady, cs, OutValid, OutData, OutIndex, OutLast, Busy
  );

  modport slave (
    output Tick, ReqValid, ReqStart, ReqCount, BusIn, OutReady,
    input  ReqReady, cs, OutValid, OutData, OutIndex, OutLast, Busy
  );
endinterface

// File: rtl/reg_bus_read_sequencer.sv
// Burst reader for the shared tri-state register bus.
// It selects one register at a time, with a settle cycle and a turnaround cycle, then streams out each sampled word.
module reg_bus_read_sequencer #(
  parameter int unsigned NrOfBits = 8,
  parameter int unsigned NrOfRegs = 4,
  parameter int unsigned IdxBits  = 2,
  parameter int unsigned CntBits  = 3
) (
  input  logic                          Clock,
  input  logic                          Reset,
  reg_bus_read_sequencer_if.master      bus
);

  localparam int unsigned LastIdx = NrOfRegs - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SAMPLE = 3'd2,
    S_HOLD   = 3'd3,
    S_TURN   = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IdxBits-1:0]  r_idx, w_idx_nxt;
  logic [CntBits-1:0]  r_rem, w_rem_nxt;
  logic [NrOfRegs-1:0] r_cs, w_cs_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic [NrOfBits-1:0] r_out_data, w_out_data_nxt;
  logic [IdxBits-1:0]  r_out_index, w_out_index_nxt;
  logic                r_out_last, w_out_last_nxt;
  logic                r_req_ready, w_req_ready_nxt;
  logic                r_busy, w_busy_nxt;

  logic [IdxBits-1:0]  w_start;
  logic [CntBits-1:0]  w_count;
  logic [IdxBits-1:0]  w_idx_inc;
  logic                w_handshake;
  logic                w_sel;

  // Normalise the request: an out-of-range start folds back, and an oversized count clamps to NrOfRegs.
  always_comb begin
    w_start = bus.ReqStart;
    if (32'(bus.ReqStart) >= NrOfRegs) begin
      w_start = IdxBits'(32'(bus.ReqStart) - NrOfRegs);
    end
    w_count = bus.ReqCount;
    if (32'(bus.ReqCount) > NrOfRegs) begin
      w_count = CntBits'(NrOfRegs);
    end
    w_idx_inc   = (32'(r_idx) == LastIdx) ? '0 : r_idx + IdxBits'(1);
    w_handshake = r_out_valid & bus.OutReady;
  end

  // State and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rem       <= '0;
      r_cs        <= '1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_rem       <= w_rem_nxt;
      r_cs        <= w_cs_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_index <= w_out_index_nxt;
      r_out_last  <= w_out_last_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next state. Only the HOLD handshake may advance without Tick.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rem_nxt   = r_rem;
    unique case (r_state)
      S_IDLE: begin
        if (bus.Tick && bus.ReqValid) begin
          w_idx_nxt = w_start;
          w_rem_nxt = w_count;
          if (w_count != '0) w_state_nxt = S_SELECT;
        end
      end
      S_SELECT: if (bus.Tick) w_state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        if (bus.Tick) begin
          w_state_nxt = S_HOLD;
          w_rem_nxt   = r_rem - CntBits'(1);
        end
      end
      S_HOLD: if (w_handshake) w_state_nxt = S_TURN;
      S_TURN: begin
        if (bus.Tick) begin
          if (r_rem != '0) begin
            w_idx_nxt   = w_idx_inc;
            w_state_nxt = S_SELECT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next-values. The cs decode uses only in-range bits, so at most one select is ever low.
  always_comb begin
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_index_nxt = r_out_index;
    w_out_last_nxt  = r_out_last;
    w_sel           = (w_state_nxt == S_SELECT) || (w_state_nxt == S_SAMPLE);
    w_cs_nxt        = '1;
    for (int unsigned i = 0; i < NrOfRegs; i++) begin
      w_cs_nxt[i] = !(w_sel && (32'(w_idx_nxt) == i));
    end
    if ((r_state == S_SAMPLE) && bus.Tick) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = bus.BusIn;
      w_out_index_nxt = r_idx;
      w_out_last_nxt  = (r_rem == CntBits'(1));
    end else if ((r_state == S_HOLD) && w_handshake) begin
      w_out_valid_nxt = 1'b0;
    end
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  assign bus.ReqReady = r_req_ready;
  assign bus.Busy     = r_busy;
  assign bus.cs       = r_cs;
  assign bus.OutValid = r_out_valid;
  assign bus.OutData  = r_out_data;
  assign bus.OutIndex = r_out_index;
  assign bus.OutLast  = r_out_last;

endmodule

// File: tb/tb_reg_bus_read_sequencer.sv
// Directed bench for reg_bus_read_sequencer.
// A register-bank bus model feeds the design, a scoreboard queue checks every accepted word, and a monitor checks the cs invariants.
module tb_reg_bus_read_sequencer;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  exp_t sb[$];
  logic [7:0] regs [4];
  logic [3:0] prev_cs;

  reg_bus_read_sequencer_if #(.NrOfBits(8), .NrOfRegs(4), .IdxBits(2), .CntBits(3)) bus ();

  reg_bus_read_sequencer #(.NrOfBits(8), .NrOfRegs(4), .IdxBits(2), .CntBits(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Register bank: the selected register drives the bus; an idle bus reads as zero.
  always_comb begin
    bus.BusIn = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (!bus.cs[i]) bus.BusIn = regs[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop plus the cs invariants, sampled on the falling edge.
  always @(negedge Clock) begin
    if (Reset) begin
      prev_cs <= 4'hF;
    end else begin
      chk("cs_onehot_low", 32'($countones(~bus.cs) <= 1), 32'd1);
      if (bus.cs != 4'hF && prev_cs != 4'hF) chk("cs_gap", 32'(bus.cs), 32'(prev_cs));
      if (bus.OutValid) chk("cs_idle_in_hold", 32'(bus.cs), 32'hF);
      prev_cs <= bus.cs;
      if (bus.OutValid && bus.OutReady) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'(bus.OutData), 32'hFFFF_FFFF);
        end else begin
          chk("word", 32'({bus.OutData, bus.OutIndex, bus.OutLast}), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic request(input logic [1:0] start, input logic [2:0] count);
    bus.ReqValid = 1'b1;
    bus.ReqStart = start;
    bus.ReqCount = count;
    cyc();
    bus.ReqValid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      cyc();
      if (bus.ReqReady && !bus.OutValid && sb.size() == 0) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int base;
    bit seen;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
    bus.Tick = 1'b1; bus.ReqValid = 1'b0; bus.ReqStart = '0; bus.ReqCount = '0;
    bus.OutReady = 1'b1;
    cyc(); cyc();
    Reset = 1'b0;
    chk("rst_cs", 32'(bus.cs), 32'hF);
    chk("rst_valid", 32'(bus.OutValid), 32'd0);
    chk("rst_ready", 32'(bus.ReqReady), 32'd1);
    chk("rst_busy", 32'(bus.Busy), 32'd0);

    // Single read of register 2: two select cycles, then the word.
    sb.push_back(exp_t'{8'h33, 2'd2, 1'b1});
    request(2'd2, 3'd1);
    chk("single_cs1", 32'(bus.cs), 32'hB);
    chk("single_busy", 32'(bus.Busy), 32'd1);
    cyc();
    chk("single_cs2", 32'(bus.cs), 32'hB);
    chk("single_nv", 32'(bus.OutValid), 32'd0);
    cyc();
    chk("single_cs3", 32'(bus.cs), 32'hF);
    chk("single_valid", 32'(bus.OutValid), 32'd1);
    chk("single_data", 32'(bus.OutData), 32'h33);
    chk("single_last", 32'(bus.OutLast), 32'd1);
    cyc();
    chk("single_turn_nv", 32'(bus.OutValid), 32'd0);
    cyc();
    chk("single_idle", 32'(bus.ReqReady), 32'd1);

    // Wrapping burst 3 -> 0 -> 1.
    sb.push_back(exp_t'{8'h44, 2'd3, 1'b0});
    sb.push_back(exp_t'{8'h11, 2'd0, 1'b0});
    sb.push_back(exp_t'{8'h22, 2'd1, 1'b1});
    request(2'd3, 3'd3);
    wait_drain("wrap_drain");

    // Backpressure, with a request that must be ignored while busy.
    bus.OutReady = 1'b0;
    base = hs_cnt;
    sb.push_back(exp_t'{8'h22, 2'd1, 1'b1});
    request(2'd1, 3'd1);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (bus.OutValid) seen = 1'b1; else cyc();
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    bus.ReqValid = 1'b1; bus.ReqStart = 2'd3; bus.ReqCount = 3'd2;
    for (int n = 0; n < 5; n++) begin
      chk("bp_hold_valid", 32'(bus.OutValid), 32'd1);
      chk("bp_hold_data", 32'(bus.OutData), 32'h22);
      chk("bp_hold_cs", 32'(bus.cs), 32'hF);
      cyc();
    end
    bus.ReqValid = 1'b0;
    bus.OutReady = 1'b1;
    wait_drain("bp_drain");
    chk("bp_once", 32'(hs_cnt - base), 32'd1);
    cyc();
    chk("bp_ignored_req", 32'(bus.Busy), 32'd0);

    // Tick gating; the handshake still completes while Tick is low.
    sb.push_back(exp_t'{8'h11, 2'd0, 1'b0});
    sb.push_back(exp_t'{8'h22, 2'd1, 1'b1});
    bus.OutReady = 1'b0; bus.Tick = 1'b0;
    bus.ReqValid = 1'b1; bus.ReqStart = 2'd0; bus.ReqCount = 3'd2;
    cyc();
    chk("tick_no_accept", 32'(bus.ReqReady), 32'd1);
    bus.Tick = 1'b1; cyc(); bus.ReqValid = 1'b0;
    chk("tick_sel", 32'(bus.cs), 32'hE);
    bus.Tick = 1'b0; cyc();
    chk("tick_frz1", 32'(bus.cs), 32'hE);
    bus.Tick = 1'b1; cyc();
    chk("tick_smp_nv", 32'(bus.OutValid), 32'd0);
    bus.Tick = 1'b0; cyc();
    chk("tick_frz2", 32'(bus.OutValid), 32'd0);
    chk("tick_frz2_cs", 32'(bus.cs), 32'hE);
    bus.Tick = 1'b1; cyc();
    chk("tick_hold", 32'(bus.OutValid), 32'd1);
    bus.Tick = 1'b0; bus.OutReady = 1'b1; cyc();
    chk("tick_hs_notick", 32'(bus.OutValid), 32'd0);
    cyc();
    chk("tick_turn_frz", 32'(bus.cs), 32'hF);
    chk("tick_turn_busy", 32'(bus.Busy), 32'd1);
    bus.Tick = 1'b1; cyc();
    chk("tick_next_sel", 32'(bus.cs), 32'hD);
    wait_drain("tick_drain");

    // Count 0 is consumed silently; count 7 clamps to four words.
    base = hs_cnt;
    request(2'd0, 3'd0);
    chk("cnt0_idle", 32'(bus.ReqReady), 32'd1);
    cyc(); cyc();
    chk("cnt0_nv", 32'(bus.OutValid), 32'd0);
    chk("cnt0_cs", 32'(bus.cs), 32'hF);
    sb.push_back(exp_t'{8'h22, 2'd1, 1'b0});
    sb.push_back(exp_t'{8'h33, 2'd2, 1'b0});
    sb.push_back(exp_t'{8'h44, 2'd3, 1'b0});
    sb.push_back(exp_t'{8'h11, 2'd0, 1'b1});
    request(2'd1, 3'd7);
    wait_drain("cnt7_drain");
    chk("cnt7_words", 32'(hs_cnt - base), 32'd4);

    // Reset in the middle of SAMPLE.
    request(2'd2, 3'd2);
    cyc();
    Reset = 1'b1; cyc(); cyc(); Reset = 1'b0;
    chk("mrst_cs", 32'(bus.cs), 32'hF);
    chk("mrst_valid", 32'(bus.OutValid), 32'd0);
    chk("mrst_data", 32'(bus.OutData), 32'h0);
    chk("mrst_ready", 32'(bus.ReqReady), 32'd1);
    chk("mrst_busy", 32'(bus.Busy), 32'd0);
    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
